// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory arbiter and its picker.
package mem_arbiter_pkg;
  localparam logic [1:0] LEN_B   = 2'b00;
  localparam logic [1:0] LEN_H   = 2'b01;
  localparam logic [1:0] LEN_BAD = 2'b10;
  localparam logic [1:0] LEN_W   = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_MA} owner_e;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-way request picker; MEM_ARB_RR_EN selects round-robin, otherwise MA has fixed priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   if_req_i,
  input  logic   ma_req_i,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_i,
`endif
  output logic   valid_o,
  output owner_e win_o
);
  assign valid_o = if_req_i | ma_req_i;
`ifdef MEM_ARB_RR_EN
  assign win_o = (if_req_i & ma_req_i) ? (last_i == OWN_MA ? OWN_IF : OWN_MA)
                                       : (ma_req_i ? OWN_MA : OWN_IF);
`else
  assign win_o = ma_req_i ? OWN_MA : OWN_IF;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and memory-access ports, bounded by a timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed MA-over-IF priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [1:0]        ma_len,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_ack,
  output logic              err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [1:0]        mem_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  state_e              state_q, state_d;
  owner_e              owner_q, owner_d, win;
  logic                req_v, err_q, err_d, we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, if_rdata_q, if_rdata_d, ma_rdata_q, ma_rdata_d;
`ifdef MEM_ARB_RR_EN
  owner_e              last_q, last_d;
`endif
  arb_pick u_pick (
    .if_req_i(if_req),
    .ma_req_i(ma_req),
`ifdef MEM_ARB_RR_EN
    .last_i  (last_q),
`endif
    .valid_o (req_v),
    .win_o   (win)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ma_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ma_rdata_q <= ma_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    err_d      = err_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ma_rdata_d = ma_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: if (req_v) begin
        owner_d = win;
        cnt_d   = '0;
        addr_d  = win == OWN_MA ? ma_addr : if_addr;
        wdata_d = win == OWN_MA ? ma_wdata : '0;
        len_d   = win == OWN_MA ? ma_len : LEN_W;
        we_d    = win == OWN_MA && ma_we;
        err_d   = win == OWN_MA && ma_len == LEN_BAD;
        state_d = err_d ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ack) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = mem_rdata;
            else ma_rdata_d = mem_rdata;
          end
        end else if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q == OWN_IF) if_rdata_d = '0;
          else ma_rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
`ifdef MEM_ARB_RR_EN
        last_d  = owner_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_re    = state_q == BUSY && !we_q;
    mem_we    = state_q == BUSY && we_q;
    if_ack    = state_q == RESP && owner_q == OWN_IF;
    ma_ack    = state_q == RESP && owner_q == OWN_MA;
    err       = state_q == RESP && err_q;
    mem_len   = len_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_rdata  = if_rdata_q;
    ma_rdata  = ma_rdata_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; stimulus queues expected acks, a negedge monitor checks them.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 0, if_ack, ma_req = 0, ma_we = 0, ma_ack, err;
  logic        mem_re, mem_we, mem_ack = 0;
  logic [1:0]  ma_len = 0, mem_len;
  logic [31:0] if_addr = 0, if_rdata, ma_addr = 0, ma_wdata = 0, ma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ma_req(ma_req), .ma_we(ma_we), .ma_len(ma_len), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_ack(ma_ack), .err(err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ma; bit e; logic [31:0] ird; logic [31:0] mrd; int strb;
    logic [31:0] addr; logic [31:0] wdata; logic [1:0] len; bit we;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        cur;
  int          n_cmp = 0, n_bad = 0, hung = 0, strb = 0;
  bit          done = 0;
  logic [31:0] if_m = 0, ma_m = 0, s_addr = 0, s_wdata = 0;
  logic [1:0]  s_len = 0;
  logic        s_we = 0;

  function void chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_ctl", {59'd0, mem_re, mem_we, if_ack, ma_ack, err}, 64'd0);
      chk("reset_data", {30'd0, mem_len, mem_addr | mem_wdata | if_rdata | ma_rdata}, 64'd0);
      strb = 0;
    end else begin
      if (mem_re | mem_we) begin
        strb++;
        s_addr = mem_addr; s_wdata = mem_wdata; s_len = mem_len; s_we = mem_we;
      end
      if (if_ack | ma_ack) begin
        if (exp_q.size() == 0) chk("unexpected_ack", {62'd0, if_ack, ma_ack}, 64'd0);
        else begin
          cur = exp_q.pop_front();
          chk("ack_port", {62'd0, if_ack, ma_ack}, cur.ma ? 64'd1 : 64'd2);
          chk("err", {63'd0, err}, {63'd0, cur.e});
          chk("if_rdata", {32'd0, if_rdata}, {32'd0, cur.ird});
          chk("ma_rdata", {32'd0, ma_rdata}, {32'd0, cur.mrd});
          chk("strobe_cycles", 64'(strb), 64'(cur.strb));
          if (cur.strb > 0) begin
            chk("mem_addr", {32'd0, s_addr}, {32'd0, cur.addr});
            chk("mem_wdata", {32'd0, s_wdata}, {32'd0, cur.wdata});
            chk("mem_len_we", {61'd0, s_len, s_we}, {61'd0, cur.len, cur.we});
          end
        end
        strb = 0;
      end
    end
    if (done) begin
      chk("pending_expect", 64'(exp_q.size()), 64'd0);
      chk("hung_waits", 64'(hung), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic expect_ack(input bit ma, input bit e, input int s, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] l, input bit w);
    exp_t x;
    x.ma = ma; x.e = e; x.ird = if_m; x.mrd = ma_m; x.strb = s;
    x.addr = a; x.wdata = wd; x.len = l; x.we = w;
    exp_q.push_back(x);
  endtask

  task automatic issue(input bit ma, input bit we, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (ma) begin ma_req = 1; ma_we = we; ma_len = len; ma_addr = addr; ma_wdata = wd; end
    else begin if_req = 1; if_addr = addr; end
  endtask

  // acts as memory: acks in strobe cycle dly (negative = never) until n requester acks seen
  task automatic run_mem(input int n, input int dly, input logic [31:0] rd, input bit drop_each);
    int k = 0, got = 0;
    for (int c = 0; c < 64 && got < n; c++) begin
      @(negedge clk);
      if (if_ack | ma_ack) begin
        got++; k = 0; mem_ack = 0;
        if (drop_each && if_ack) if_req = 0;
        if (drop_each && ma_ack) ma_req = 0;
      end else if (mem_re | mem_we) begin
        mem_ack = (k == dly); mem_rdata = rd + got; k++;
      end else mem_ack = 0;
    end
    if_req = 0; ma_req = 0; mem_ack = 0;
    if (got < n) hung++;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    if_m = 32'hDEADBEEF;
    expect_ack(0, 0, 4, 32'h100, 0, 2'b11, 0);
    issue(0, 0, 2'b11, 32'h100, 0);
    run_mem(1, 3, 32'hDEADBEEF, 1);
    for (int k = 0; k < 4; k++) begin
      bit own = RR ? (k % 2 == 0) : 1'b1;
      if (own) ma_m = 32'hA0 + k; else if_m = 32'hA0 + k;
      expect_ack(own, 0, 1, own ? 32'h3000 : 32'h4000, 0, own ? 2'b01 : 2'b11, 0);
    end
    issue(1, 0, 2'b01, 32'h3000, 0);
    issue(0, 0, 2'b11, 32'h4000, 0);
    run_mem(4, 0, 32'hA0, 0);
    ma_m = 32'h12345678;
    expect_ack(1, 0, 2, 32'h2000, 0, 2'b11, 0);
    issue(1, 0, 2'b11, 32'h2000, 0);
    run_mem(1, 1, 32'h12345678, 1);
    expect_ack(1, 0, 1, 32'h2004, 32'h55, 2'b00, 1);
    issue(1, 1, 2'b00, 32'h2004, 32'h55);
    run_mem(1, 0, 32'hFFFF0000, 1);
    expect_ack(1, 1, 0, 0, 0, 0, 0);
    issue(1, 0, 2'b10, 32'h2008, 0);
    run_mem(1, 0, 32'h0BAD0BAD, 1);
    ma_m = 0;
    expect_ack(1, 1, 8, 32'h2010, 0, 2'b11, 0);
    issue(1, 0, 2'b11, 32'h2010, 0);
    run_mem(1, -1, 32'h77777777, 1);
    if_m = 32'hCAFEF00D;
    expect_ack(0, 0, 1, 32'h104, 0, 2'b11, 0);
    issue(0, 0, 2'b11, 32'h104, 0);
    run_mem(1, 0, 32'hCAFEF00D, 1);
    issue(0, 0, 2'b11, 32'h108, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    if_req = 0; if_m = 0; ma_m = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (4) @(negedge clk);
    ma_m = 32'hB0;
    expect_ack(1, 0, 1, 32'h2020, 0, 2'b11, 0);
    if_m = 32'hB1;
    expect_ack(0, 0, 1, 32'h10C, 0, 2'b11, 0);
    issue(1, 0, 2'b11, 32'h2020, 0);
    issue(0, 0, 2'b11, 32'h10C, 0);
    run_mem(2, 0, 32'hB0, 1);
    done = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
